calc_key_entry: RTL

- Keypad front end of the calculator, directly upstream of the arithmetic stage.
- Turns raw key presses into the sign-magnitude operands V1 (current entry) and V2 (accumulator), the 2-bit operator code, and the single-cycle newop/newhex/eq strobes the arithmetic stage consumes.
- Handles chained operations by loading the arithmetic stage's answer back into V2.
- Drives the value shown on the display.

---
 rtl/calc_key_entry.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/calc_key_entry.sv
// -----------------------------------------------------------------------------
// calc_key_entry
//   Keypad front end of the calculator. Converts raw key presses into the
//   sign-magnitude operands handed to the arithmetic stage, selects the
//   operator, loads the arithmetic stage's answer back into the accumulator
//   when operations are chained, and chooses the value shown on the display.
//
// Ports
//   clock       in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   key_down    in   1   level, high while a key is held
//   keycode     in   5   key identity, stable while key_down is high
//   answer      in  17   sign-magnitude result from the arithmetic stage
//   V1          out 17   current entry, sign-magnitude (bit 16 = sign)
//   V2          out 17   accumulator / first operand, sign-magnitude
//   opcode      out  2   00 add, 01 multiply, 10 subtract (V2 - V1)
//   newop       out  1   one-cycle strobe, operator selected or clear
//   newhex      out  1   one-cycle strobe, entry changed
//   eq          out  1   one-cycle strobe, equals accepted
//   disp_value  out 17   value to display
//   entry_full  out  1   entry holds DIGITS significant digits
// -----------------------------------------------------------------------------
module calc_key_entry #(
   parameter int DIGITS = 4   // magnitude width 4*DIGITS must be 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        key_down,
   input  logic [4:0]  keycode,
   input  logic [16:0] answer,
   output logic [16:0] V1,
   output logic [16:0] V2,
   output logic [1:0]  opcode,
   output logic        newop,
   output logic        newhex,
   output logic        eq,
   output logic [16:0] disp_value,
   output logic        entry_full
);

   localparam int MAG_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

   localparam logic [4:0] K_ADD = 5'h10;
   localparam logic [4:0] K_MUL = 5'h11;
   localparam logic [4:0] K_SUB = 5'h12;
   localparam logic [4:0] K_EQU = 5'h13;
   localparam logic [4:0] K_CLR = 5'h14;
   localparam logic [4:0] K_NEG = 5'h15;

   typedef enum logic [1:0] {
      S_FIRST,    // entering first operand
      S_OPPEND,   // operator chosen, no digit yet
      S_SECOND,   // entering second operand
      S_RESULT    // equals accepted, answer on display
   } state_t;

   state_t           state;
   logic             key_q;
   logic [CNT_W-1:0] count;

   logic             key_event;
   logic [3:0]       digit;
   logic             mag_zero;

   assign key_event = key_down & ~key_q;
   assign digit     = keycode[3:0];
   assign mag_zero  = (V1[MAG_W-1:0] == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_FIRST;
         // key_q resets high so a key already held through reset is treated
         // as stale and produces no event until it is released and pressed.
         key_q  <= 1'b1;
         count  <= '0;
         V1     <= '0;
         V2     <= '0;
         opcode <= 2'b00;
         newop  <= 1'b0;
         newhex <= 1'b0;
         eq     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge values of V1, count and state.
         key_q  <= key_down;
         newop  <= 1'b0;
         newhex <= 1'b0;
         eq     <= 1'b0;

         if (key_event) begin
            if (!keycode[4]) begin
               // Digit keys 0x00-0x0F
               case (state)
                  S_FIRST, S_SECOND: begin
                     if (count != FULL_CNT) begin
                        V1[MAG_W-1:0] <= {V1[MAG_W-5:0], digit};
                        // Leading zeros do not consume a digit position.
                        if (!(mag_zero && digit == 4'd0))
                           count <= count + 1'b1;
                        newhex <= 1'b1;
                     end
                  end
                  S_OPPEND: begin
                     V1     <= {1'b0, MAG_W'(digit)};
                     count  <= CNT_W'(digit != 4'd0);
                     state  <= S_SECOND;
                     newhex <= 1'b1;
                  end
                  default: begin   // S_RESULT: start a fresh calculation
                     V1     <= {1'b0, MAG_W'(digit)};
                     V2     <= '0;
                     count  <= CNT_W'(digit != 4'd0);
                     state  <= S_FIRST;
                     newhex <= 1'b1;
                  end
               endcase
            end else begin
               case (keycode)
                  K_ADD, K_MUL, K_SUB: begin
                     opcode <= keycode[1:0];
                     newop  <= 1'b1;
                     case (state)
                        S_FIRST: begin
                           V2    <= V1;
                           V1    <= '0;
                           count <= '0;
                           state <= S_OPPEND;
                        end
                        S_OPPEND: ;   // operator replaced only
                        default: begin
                           // Chaining: answer still reflects the previous
                           // operator, which is what must be accumulated.
                           V2    <= answer;
                           V1    <= '0;
                           count <= '0;
                           state <= S_OPPEND;
                        end
                     endcase
                  end
                  K_EQU: begin
                     if (state == S_SECOND) begin
                        eq    <= 1'b1;
                        state <= S_RESULT;
                     end
                  end
                  K_CLR: begin
                     V1     <= '0;
                     V2     <= '0;
                     count  <= '0;
                     opcode <= 2'b00;
                     newop  <= 1'b1;
                     state  <= S_FIRST;
                  end
                  K_NEG: begin
                     // A zero magnitude is never negated, so -0 cannot appear.
                     if ((state == S_FIRST || state == S_SECOND) && !mag_zero) begin
                        V1[16] <= ~V1[16];
                        newhex <= 1'b1;
                     end
                  end
                  default: ;   // 0x16-0x1F ignored
               endcase
            end
         end
      end
   end

   always_comb begin
      case (state)
         S_RESULT: disp_value = answer;
         S_OPPEND: disp_value = V2;
         default:  disp_value = V1;
      endcase
   end

   assign entry_full = (count == FULL_CNT);

endmodule
